// File: rtl/l2_pmem_adaptor_if.sv
// L2-side line port and physical-memory burst port of the L2/pmem adaptor.
// The adaptor takes the slave view; the L2 cache plus memory model take the master view.
interface l2_pmem_adaptor_if #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
);
    logic [31:0]            address_i;
    logic                   read_i;
    logic                   write_i;
    logic [LINE_WIDTH-1:0]  line_i;
    logic [LINE_WIDTH-1:0]  line_o;
    logic                   resp_o;
    logic [31:0]            address_o;
    logic                   read_o;
    logic                   write_o;
    logic [BURST_WIDTH-1:0] burst_o;
    logic [BURST_WIDTH-1:0] burst_i;
    logic                   resp_i;

    modport slave (
        input  address_i, read_i, write_i, line_i, burst_i, resp_i,
        output line_o, resp_o, address_o, read_o, write_o, burst_o
    );

    modport master (
        output address_i, read_i, write_i, line_i, burst_i, resp_i,
        input  line_o, resp_o, address_o, read_o, write_o, burst_o
    );
endinterface

// File: rtl/l2_pmem_adaptor.sv
// Splits L2 line fills/write-backs into BEATS memory bursts; resp_o pulses BEATS+1 edges after the request edge.
// Memory stalls by holding resp_i low (count and data hold); L2 holds its request until resp_o.
module l2_pmem_adaptor #(
    parameter int LINE_WIDTH  = 256,
    parameter int BURST_WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    l2_pmem_adaptor_if.slave bus
);
    localparam int              BEATS      = LINE_WIDTH / BURST_WIDTH;
    localparam int              CW         = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int              LINE_BYTES = LINE_WIDTH / 8;
    localparam logic [31:0]     ADDR_MASK  = ~(32'(LINE_BYTES) - 32'd1);
    localparam logic [CW-1:0]   LAST_BEAT  = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                              state_q, state_d;
    logic [CW-1:0]                       count_q, count_d;
    logic [31:0]                         addr_q, addr_d;
    logic [BEATS-1:0][BURST_WIDTH-1:0]   rbuf_q, rbuf_d;
    logic [BEATS-1:0][BURST_WIDTH-1:0]   wbuf_q, wbuf_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            rbuf_q  <= '0;
            wbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            rbuf_q  <= rbuf_d;
            wbuf_q  <= wbuf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        rbuf_d  = rbuf_q;
        wbuf_d  = wbuf_q;
        case (state_q)
            S_IDLE: begin
                // Read has priority when L2 raises both requests together.
                if (bus.read_i) begin
                    state_d = S_READ;
                    addr_d  = bus.address_i & ADDR_MASK;
                    count_d = '0;
                end else if (bus.write_i) begin
                    state_d = S_WRITE;
                    addr_d  = bus.address_i & ADDR_MASK;
                    wbuf_d  = bus.line_i;
                    count_d = '0;
                end
            end
            S_READ: begin
                if (bus.resp_i) begin
                    rbuf_d[count_q] = bus.burst_i;
                    count_d         = count_q + CW'(1);
                    if (count_q == LAST_BEAT) begin
                        state_d = S_DONE;
                        count_d = '0;
                    end
                end
            end
            S_WRITE: begin
                if (bus.resp_i) begin
                    count_d = count_q + CW'(1);
                    if (count_q == LAST_BEAT) begin
                        state_d = S_DONE;
                        count_d = '0;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.read_o    = (state_q == S_READ);
    assign bus.write_o   = (state_q == S_WRITE);
    assign bus.resp_o    = (state_q == S_DONE);
    assign bus.address_o = addr_q;
    assign bus.line_o    = rbuf_q;
    assign bus.burst_o   = (state_q == S_WRITE) ? wbuf_q[count_q] : '0;
endmodule

// File: tb/tb_l2_pmem_adaptor.sv
// Directed bench for l2_pmem_adaptor: transaction-level reference model checked every cycle,
// plus literal expectations on the directed scenarios.
module tb_l2_pmem_adaptor;
    localparam int LW = 256;
    localparam int BW = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_pmem_adaptor_if #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) bus ();

    l2_pmem_adaptor #(.LINE_WIDTH(LW), .BURST_WIDTH(BW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Reference model: one outstanding transaction, beats accepted so far, and a completion flag.
    bit          m_busy = 1'b0;
    bit          m_rd   = 1'b0;
    bit          m_done = 1'b0;
    int          m_got  = 0;
    logic [63:0] m_r [4] = '{default: 64'd0};
    logic [63:0] m_w [4] = '{default: 64'd0};
    logic [31:0] m_addr = 32'd0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] rep(input logic [3:0] n);
        return {16{n}};
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_got  = 0;
            m_addr = 32'd0;
            for (int i = 0; i < 4; i++) m_r[i] = 64'd0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            if (bus.resp_i) begin
                if (m_rd) m_r[m_got] = bus.burst_i;
                m_got++;
                if (m_got == 4) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_got  = 0;
                end
            end
        end else if (bus.read_i || bus.write_i) begin
            m_busy = 1'b1;
            m_rd   = bus.read_i;
            m_got  = 0;
            m_addr = bus.address_i - (bus.address_i % 32);
            if (!m_rd)
                for (int i = 0; i < 4; i++) m_w[i] = bus.line_i[i*64 +: 64];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model.read_o",    256'(bus.read_o),    256'(m_busy && m_rd));
            chk("model.write_o",   256'(bus.write_o),   256'(m_busy && !m_rd));
            chk("model.resp_o",    256'(bus.resp_o),    256'(m_done));
            chk("model.address_o", 256'(bus.address_o), 256'(m_addr));
            chk("model.line_o",    bus.line_o,          {m_r[3], m_r[2], m_r[1], m_r[0]});
            chk("model.burst_o",   256'(bus.burst_o),   256'((m_busy && !m_rd) ? m_w[m_got] : 64'd0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish before time limit");
        $fatal(1);
    end

    int          t_req;
    int          n;
    logic [63:0] exp_b [6];
    bit          pat   [6];

    initial begin
        bus.address_i = '0;
        bus.read_i    = 1'b0;
        bus.write_i   = 1'b0;
        bus.line_i    = '0;
        bus.burst_i   = '0;
        bus.resp_i    = 1'b0;
        rst           = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset.read_o",    256'(bus.read_o),    256'd0);
        chk("reset.write_o",   256'(bus.write_o),   256'd0);
        chk("reset.resp_o",    256'(bus.resp_o),    256'd0);
        chk("reset.address_o", 256'(bus.address_o), 256'd0);
        chk("reset.line_o",    bus.line_o,          256'd0);

        // Line fill, beats back to back.
        bus.address_i = 32'h0000_1234;
        bus.read_i    = 1'b1;
        t_req         = cyc;
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = rep(4'(k + 1));
            tick();
        end
        bus.resp_i = 1'b0;
        bus.read_i = 1'b0;
        // Sampling cycle counts as cycle 1, so the DONE cycle is the 6th: five edges later.
        chk("rd.latency_edges", 256'(cyc - t_req), 256'd5);
        chk("rd.resp_o",    256'(bus.resp_o),    256'd1);
        chk("rd.address_o", 256'(bus.address_o), 256'h0000_1220);
        chk("rd.line_o", bus.line_o,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        tick();
        chk("rd.resp_single_pulse", 256'(bus.resp_o), 256'd0);

        // Write-back with gaps; burst_o follows the accepted-beat count in every cycle.
        bus.address_i = 32'h0000_ABCD;
        bus.line_i    = {64'hDDDDDDDDDDDDDDDD, 64'hCCCCCCCCCCCCCCCC,
                         64'hBBBBBBBBBBBBBBBB, 64'hAAAAAAAAAAAAAAAA};
        bus.write_i   = 1'b1;
        pat   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_b = '{64'hAAAAAAAAAAAAAAAA, 64'hBBBBBBBBBBBBBBBB, 64'hBBBBBBBBBBBBBBBB,
                  64'hCCCCCCCCCCCCCCCC, 64'hCCCCCCCCCCCCCCCC, 64'hDDDDDDDDDDDDDDDD};
        tick();
        for (int i = 0; i < 6; i++) begin
            bus.resp_i = pat[i];
            chk("wr.write_o", 256'(bus.write_o), 256'd1);
            chk("wr.burst_o", 256'(bus.burst_o), 256'(exp_b[i]));
            tick();
        end
        bus.resp_i  = 1'b0;
        bus.write_i = 1'b0;
        chk("wr.write_o_drop", 256'(bus.write_o),   256'd0);
        chk("wr.resp_o",       256'(bus.resp_o),    256'd1);
        chk("wr.burst_o_zero", 256'(bus.burst_o),   256'd0);
        chk("wr.address_o",    256'(bus.address_o), 256'h0000_ABC0);
        tick();

        // Both requests together: read first, write only after re-sampling in IDLE.
        bus.address_i = 32'h8000_0047;
        bus.line_i    = {64'h0D0D0D0D0D0D0D0D, 64'h0C0C0C0C0C0C0C0C,
                         64'h0B0B0B0B0B0B0B0B, 64'h0A0A0A0A0A0A0A0A};
        bus.read_i    = 1'b1;
        bus.write_i   = 1'b1;
        tick();
        chk("both.read_o",  256'(bus.read_o),  256'd1);
        chk("both.write_o", 256'(bus.write_o), 256'd0);
        for (int k = 0; k < 4; k++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = rep(4'(k + 9));
            tick();
        end
        bus.resp_i = 1'b0;
        bus.read_i = 1'b0;
        chk("both.resp_o", 256'(bus.resp_o), 256'd1);
        tick();
        chk("both.idle_write_o", 256'(bus.write_o), 256'd0);
        tick();
        chk("both.write_o_later", 256'(bus.write_o), 256'd1);
        chk("both.burst_o_beat0", 256'(bus.burst_o), 256'h0A0A0A0A0A0A0A0A);
        for (int k = 0; k < 4; k++) begin
            bus.resp_i = 1'b1;
            tick();
        end
        bus.resp_i  = 1'b0;
        bus.write_i = 1'b0;
        chk("both.wr_resp_o", 256'(bus.resp_o), 256'd1);
        chk("both.line_o_kept", bus.line_o,
            256'hCCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA_9999999999999999);
        tick();

        // Reset after two read beats, then a fresh read with no residue.
        bus.address_i = 32'h0000_0100;
        bus.read_i    = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = rep(4'(k + 1));
            tick();
        end
        bus.resp_i = 1'b0;
        rst        = 1'b1;
        tick();
        chk("rst.read_o",    256'(bus.read_o),    256'd0);
        chk("rst.resp_o",    256'(bus.resp_o),    256'd0);
        chk("rst.line_o",    bus.line_o,          256'd0);
        chk("rst.address_o", 256'(bus.address_o), 256'd0);
        rst           = 1'b0;
        bus.address_i = 32'h0000_2000;
        tick();
        chk("rst.first_read_o", 256'(bus.read_o), 256'd1);
        for (int k = 0; k < 4; k++) begin
            bus.resp_i  = 1'b1;
            bus.burst_i = rep(4'(k + 5));
            tick();
        end
        bus.resp_i = 1'b0;
        bus.read_i = 1'b0;
        chk("rst.fresh_resp_o", 256'(bus.resp_o), 256'd1);
        chk("rst.fresh_line_o", bus.line_o,
            256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555);
        tick();

        // Stray strobes in IDLE, then a read that must still need four beats.
        bus.resp_i  = 1'b1;
        bus.burst_i = rep(4'hF);
        for (int k = 0; k < 3; k++) tick();
        chk("stray.read_o", 256'(bus.read_o), 256'd0);
        chk("stray.line_o", bus.line_o,
            256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555);
        bus.address_i = 32'h0000_3010;
        bus.read_i    = 1'b1;
        tick();
        n = 0;
        while (!bus.resp_o && n < 20) begin
            bus.burst_i = rep(4'(n + 1));
            tick();
            n++;
        end
        bus.resp_i = 1'b0;
        bus.read_i = 1'b0;
        chk("stray.beats_needed", 256'(n), 256'd4);
        chk("stray.line_o", bus.line_o,
            256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
